// File: rtl/mic_peak_scheduler_if.sv
// Handshake/data bundle between the peak scheduler and its frame source / band consumer.
interface mic_peak_scheduler_if #(
  parameter int NUM_MIC = 4,
  parameter int DW      = 24,
  parameter int BW      = 9
);
  logic                  start;
  logic                  stop;
  logic                  sample_valid;
  logic [NUM_MIC*DW-1:0] mic_data_bus;
  logic                  busy;
  logic [NUM_MIC*BW-1:0] sound_band_bus;
  logic                  band_valid;
  logic                  overrun;

  modport master (
    output start, stop, sample_valid, mic_data_bus,
    input  busy, sound_band_bus, band_valid, overrun
  );

  modport slave (
    input  start, stop, sample_valid, mic_data_bus,
    output busy, sound_band_bus, band_valid, overrun
  );
endinterface

// File: rtl/mic_peak_scheduler.sv
// Shared peak-detect datapath walked across NUM_MIC channels; publishes saturated bands every WIN_LEN frames.
// Optional MIC_PEAK_DECAY_EN: peaks halve at each publish instead of clearing.
module mic_peak_scheduler #(
  parameter int NUM_MIC  = 4,
  parameter int WIN_LEN  = 1024,
  parameter int BAND_MAX = 300,
  parameter int DW       = 24,
  parameter int BW       = 9
) (
  input logic                 clk,
  input logic                 rst,
  mic_peak_scheduler_if.slave bus
);
  localparam int CW  = $clog2(WIN_LEN) + 1;
  localparam int CHW = (NUM_MIC > 1) ? $clog2(NUM_MIC) : 1;
  localparam logic [CW-1:0]  LAST_FRAME = CW'(WIN_LEN - 1);
  localparam logic [CHW-1:0] LAST_CH    = CHW'(NUM_MIC - 1);
  localparam logic [BW-1:0]  BAND_CAP   = BW'(BAND_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, PUBLISH} state_e;

  state_e                state_q, state_d;
  logic [DW-2:0]         peak_q [NUM_MIC];
  logic [DW-2:0]         peak_d [NUM_MIC];
  logic [NUM_MIC*DW-1:0] frame_q, frame_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [NUM_MIC*BW-1:0] band_q, band_d;
  logic                  bv_q, bv_d;
  logic                  ovr_q, ovr_d;

  logic [DW-1:0]         cur_sample;
  logic [DW-2:0]         cur_abs;
  logic [NUM_MIC*BW-1:0] bands;
  logic [BW-1:0]         slice;

  always_comb begin
    cur_sample = '0;
    for (int unsigned k = 0; k < NUM_MIC; k++) begin
      if (ch_q == CHW'(k)) cur_sample = frame_q[k*DW +: DW];
    end
    cur_abs = cur_sample[DW-1] ? '0 : cur_sample[DW-2:0];
  end

  always_comb begin
    bands = '0;
    slice = '0;
    for (int unsigned k = 0; k < NUM_MIC; k++) begin
      slice = peak_q[k][DW-2 -: BW];
      bands[k*BW +: BW] = (slice > BAND_CAP) ? BAND_CAP : slice;
    end
  end

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    band_d  = band_q;
    bv_d    = 1'b0;
    ovr_d   = ovr_q;

    // stop outranks start, sample_valid and publish in every state
    if (bus.stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      ch_d    = '0;
      for (int unsigned k = 0; k < NUM_MIC; k++) peak_d[k] = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = WAIT;
            ovr_d   = 1'b0;
          end
        end
        WAIT: begin
          if (bus.sample_valid) begin
            frame_d = bus.mic_data_bus;
            ch_d    = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (bus.sample_valid) ovr_d = 1'b1;
          for (int unsigned k = 0; k < NUM_MIC; k++) begin
            if (ch_q == CHW'(k) && cur_abs >= peak_q[k]) peak_d[k] = cur_abs;
          end
          if (ch_q == LAST_CH) begin
            if (cnt_q == LAST_FRAME) begin
              cnt_d   = '0;
              state_d = PUBLISH;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = WAIT;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
        PUBLISH: begin
          if (bus.sample_valid) ovr_d = 1'b1;
          band_d  = bands;
          bv_d    = 1'b1;
          state_d = WAIT;
          for (int unsigned k = 0; k < NUM_MIC; k++) begin
`ifdef MIC_PEAK_DECAY_EN
            peak_d[k] = peak_q[k] >> 1;
`else
            peak_d[k] = '0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      band_q  <= '0;
      bv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_MIC; k++) peak_q[k] <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      band_q  <= band_d;
      bv_q    <= bv_d;
      ovr_q   <= ovr_d;
      peak_q  <= peak_d;
    end
  end

  assign bus.busy           = (state_q == SCAN) || (state_q == PUBLISH);
  assign bus.sound_band_bus = band_q;
  assign bus.band_valid     = bv_q;
  assign bus.overrun        = ovr_q;
endmodule
